// File: rtl/relu_serializer.sv
// relu_serializer: captures one layer's parallel results in a single cycle,
// applies ReLU at capture, and replays them as a serial stream. The stream
// pulses o_valid on sample 0 and o_last on the final sample. One frame may
// wait in a pending buffer while a stream is in flight.
module relu_serializer #(
   parameter int DATA_WIDTH  = 24,
   parameter int NUM_NEURONS = 10,
   parameter int APPLY_RELU  = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_valid,
   input  logic [NUM_NEURONS*DATA_WIDTH-1:0] din,
   output logic                              o_valid,
   output logic                              o_last,
   output logic                              o_busy,
   output logic                              o_overflow,
   output logic [DATA_WIDTH-1:0]             dout
);

   localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] GAP    = 2'd2;

   logic [1:0]                                  state;
   logic [IW-1:0]                               idx;
   logic                                        pending_valid;
   logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]      active;
   logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]      pending;
   logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]      din_relu;

   // Per-neuron clamp of the incoming frame; negative samples become zero
   // so the buffers only ever hold already-rectified values.
   for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_relu
      logic [DATA_WIDTH-1:0] raw;
      assign raw         = din[g*DATA_WIDTH +: DATA_WIDTH];
      assign din_relu[g] = ((APPLY_RELU != 0) && raw[DATA_WIDTH-1]) ? '0 : raw;
   end

   // Frame capture, pending-buffer management and serial replay.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= '0;
         pending_valid <= 1'b0;
         active        <= '0;
         pending       <= '0;
         o_valid       <= 1'b0;
         o_last        <= 1'b0;
         o_busy        <= 1'b0;
         o_overflow    <= 1'b0;
         dout          <= '0;
      end else begin
         case (state)
            IDLE: begin
               dout    <= '0;
               o_valid <= 1'b0;
               o_last  <= 1'b0;
               o_busy  <= 1'b0;
               idx     <= '0;
               if (i_valid) begin
                  active <= din_relu;
                  state  <= STREAM;
               end
            end
            STREAM: begin
               dout    <= active[idx];
               o_valid <= (idx == '0);
               o_last  <= (idx == LAST_IDX);
               o_busy  <= 1'b1;
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= GAP;
               end else begin
                  idx <= idx + IW'(1);
               end
               // A frame arriving mid-stream waits; a second one has nowhere to go.
               if (i_valid) begin
                  if (!pending_valid) begin
                     pending       <= din_relu;
                     pending_valid <= 1'b1;
                  end else begin
                     o_overflow <= 1'b1;
                  end
               end
            end
            GAP: begin
               // One idle cycle lets the downstream counter re-arm.
               dout    <= '0;
               o_valid <= 1'b0;
               o_last  <= 1'b0;
               o_busy  <= 1'b1;
               idx     <= '0;
               if (pending_valid) begin
                  active <= pending;
                  state  <= STREAM;
                  if (i_valid) pending <= din_relu;
                  else         pending_valid <= 1'b0;
               end else if (i_valid) begin
                  active <= din_relu;
                  state  <= STREAM;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               dout    <= '0;
               o_valid <= 1'b0;
               o_last  <= 1'b0;
               o_busy  <= 1'b0;
               idx     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_relu_serializer.sv
// Bench for relu_serializer (NUM_NEURONS=4, DATA_WIDTH=24). Two instances share
// the stimulus: one with ReLU and one without. A schedule model assigns each
// accepted frame a start cycle.
module tb_relu_serializer;
   localparam int DW = 24;
   localparam int NN = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_valid = 1'b0;
   logic [NN*DW-1:0] din = '0;
   logic o_valid, o_last, o_busy, o_overflow;
   logic [DW-1:0] dout;
   logic n_valid, n_last, n_busy, n_overflow;
   logic [DW-1:0] n_dout;

   relu_serializer #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .APPLY_RELU(1)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
      .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy),
      .o_overflow(o_overflow), .dout(dout));

   relu_serializer #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .APPLY_RELU(0)) dut_nr (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din),
      .o_valid(n_valid), .o_last(n_last), .o_busy(n_busy),
      .o_overflow(n_overflow), .dout(n_dout));

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   localparam logic [NN*DW-1:0] FR_F = {24'h000400, 24'hFFFC00, 24'h000001, 24'h000800};
   localparam logic [NN*DW-1:0] FR_G = {24'h800000, 24'h123456, 24'h7FFFFF, 24'hABCDEF};
   localparam logic [NN*DW-1:0] FR_H = {24'h000003, 24'h000002, 24'h000001, 24'h00000A};

   // ---------------- schedule model ----------------
   typedef struct {
      int                           s;
      logic [NN-1:0][DW-1:0]        r;
      logic [NN-1:0][DW-1:0]        raw;
   } frame_t;
   frame_t fr[$];
   bit     m_ovf = 0;

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
      return v[DW-1] ? '0 : v;
   endfunction

   // A frame is "live" until its gap cycle; two live frames means no room.
   task automatic model_edge();
      int     live;
      int     last_s;
      frame_t f;
      live = 0;
      last_s = 0;
      if (i_valid) begin
         foreach (fr[i]) if (fr[i].s + NN > cyc) begin live++; last_s = fr[i].s; end
         if (live >= 2) m_ovf = 1;
         else begin
            f.s = (live == 0) ? cyc + 1 : last_s + NN + 1;
            for (int k = 0; k < NN; k++) begin
               f.raw[k] = din[k*DW +: DW];
               f.r[k]   = relu(din[k*DW +: DW]);
            end
            fr.push_back(f);
         end
      end
   endtask

   task automatic check_model();
      logic [DW-1:0] ed, en;
      logic ev, el, eb;
      ed = '0; en = '0; ev = 0; el = 0; eb = 0;
      foreach (fr[i]) begin
         if (cyc >= fr[i].s && cyc <= fr[i].s + NN - 1) begin
            ed = fr[i].r[cyc - fr[i].s];
            en = fr[i].raw[cyc - fr[i].s];
            ev = (cyc == fr[i].s);
            el = (cyc == fr[i].s + NN - 1);
         end
         if (cyc >= fr[i].s && cyc <= fr[i].s + NN) eb = 1;
      end
      vectors++;
      if (dout !== ed || o_valid !== ev || o_last !== el || o_busy !== eb ||
          o_overflow !== m_ovf || n_dout !== en || n_valid !== ev ||
          n_last !== el || n_busy !== eb || n_overflow !== m_ovf) begin
         errors++;
         $display("FAIL model cyc=%0d got dout=%h v=%b l=%b b=%b ovf=%b nr=%h want dout=%h v=%b l=%b b=%b ovf=%b nr=%h",
                  cyc, dout, o_valid, o_last, o_busy, o_overflow, n_dout,
                  ed, ev, el, eb, m_ovf, en);
      end
   endtask

   task automatic step(input logic iv, input logic [NN*DW-1:0] d);
      i_valid = iv;
      din     = d;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_model();
      i_valid = 1'b0;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      rst = 1'b0;
      fr.delete();
      m_ovf = 0;
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1;
      chk("reset_outputs", {dout, n_dout}, '0);
      chk("reset_flags", {o_valid, o_last, o_busy, o_overflow}, '0);
      rst = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic              iv;
      logic [NN*DW-1:0]  d;
      logic [DW-1:0]     e_dout;
      logic [DW-1:0]     e_nr;
      logic              ev, el, eb;
   } vec_t;
   vec_t tbl[19];

   function automatic vec_t mk(input logic iv, input logic [NN*DW-1:0] d,
                               input logic [DW-1:0] ed, input logic [DW-1:0] en,
                               input logic ev, input logic el, input logic eb);
      vec_t v;
      v.iv = iv; v.d = d; v.e_dout = ed; v.e_nr = en; v.ev = ev; v.el = el; v.eb = eb;
      return v;
   endfunction

   int pulses;

   initial begin
      // single frame, with and without ReLU
      tbl[0]  = mk(1, FR_F, 24'h000000, 24'h000000, 0, 0, 0);
      tbl[1]  = mk(0, '0,   24'h000800, 24'h000800, 1, 0, 1);
      tbl[2]  = mk(0, '0,   24'h000001, 24'h000001, 0, 0, 1);
      tbl[3]  = mk(0, '0,   24'h000000, 24'hFFFC00, 0, 0, 1);
      tbl[4]  = mk(0, '0,   24'h000400, 24'h000400, 0, 1, 1);
      tbl[5]  = mk(0, '0,   24'h000000, 24'h000000, 0, 0, 1);
      tbl[6]  = mk(0, '0,   24'h000000, 24'h000000, 0, 0, 0);
      // second frame arriving at t+2 waits for the gap
      tbl[7]  = mk(1, FR_F, 24'h000000, 24'h000000, 0, 0, 0);
      tbl[8]  = mk(0, '0,   24'h000800, 24'h000800, 1, 0, 1);
      tbl[9]  = mk(1, FR_G, 24'h000001, 24'h000001, 0, 0, 1);
      tbl[10] = mk(0, '0,   24'h000000, 24'hFFFC00, 0, 0, 1);
      tbl[11] = mk(0, '0,   24'h000400, 24'h000400, 0, 1, 1);
      tbl[12] = mk(0, '0,   24'h000000, 24'h000000, 0, 0, 1);
      tbl[13] = mk(0, '0,   24'h000000, 24'hABCDEF, 1, 0, 1);
      tbl[14] = mk(0, '0,   24'h7FFFFF, 24'h7FFFFF, 0, 0, 1);
      tbl[15] = mk(0, '0,   24'h123456, 24'h123456, 0, 0, 1);
      tbl[16] = mk(0, '0,   24'h000000, 24'h800000, 0, 1, 1);
      tbl[17] = mk(0, '0,   24'h000000, 24'h000000, 0, 0, 1);
      tbl[18] = mk(0, '0,   24'h000000, 24'h000000, 0, 0, 0);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         i_valid = tbl[i].iv;
         din     = tbl[i].d;
         @(posedge clk);
         cyc++;
         model_edge();
         #1;
         i_valid = 1'b0;
         vectors++;
         if (dout !== tbl[i].e_dout || n_dout !== tbl[i].e_nr || o_valid !== tbl[i].ev ||
             o_last !== tbl[i].el || o_busy !== tbl[i].eb || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL table[%0d] got dout=%h nr=%h v=%b l=%b b=%b ovf=%b want dout=%h nr=%h v=%b l=%b b=%b ovf=0",
                     i, dout, n_dout, o_valid, o_last, o_busy, o_overflow,
                     tbl[i].e_dout, tbl[i].e_nr, tbl[i].ev, tbl[i].el, tbl[i].eb);
         end
      end

      // third frame while pending is full is dropped
      do_reset();
      step(1, FR_F);
      step(0, '0);
      step(1, FR_G);
      chk("ovf_before_drop", {23'd0, o_overflow}, 24'd0);
      step(1, FR_H);
      step(0, '0);
      chk("ovf_after_drop", {23'd0, o_overflow}, 24'd1);
      pulses = 1;
      for (int i = 0; i < 12; i++) begin
         step(0, '0);
         if (o_valid) pulses++;
      end
      chk("drop_stream_count", 24'(pulses), 24'd2);
      chk("ovf_sticky", {23'd0, o_overflow}, 24'd1);

      // frame arriving exactly on the gap cycle
      do_reset();
      step(1, FR_F);
      for (int i = 0; i < 4; i++) step(0, '0);
      step(1, FR_H);
      step(0, '0);
      chk("gap_start_dout", dout, 24'h00000A);
      chk("gap_start_valid", {23'd0, o_valid}, 24'd1);
      for (int i = 0; i < 6; i++) step(0, '0);

      // asynchronous reset mid-stream
      do_reset();
      step(1, FR_F);
      step(0, '0);
      step(0, '0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_dout", dout, '0);
      chk("async_rst_flags", {20'd0, o_valid, o_last, o_busy, o_overflow}, '0);
      fr.delete();
      m_ovf = 0;
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1 rst = 1'b1;
      step(1, FR_H);
      step(0, '0);
      chk("post_rst_dout", dout, 24'h00000A);
      chk("post_rst_valid", {23'd0, o_valid}, 24'd1);
      for (int i = 0; i < 6; i++) step(0, '0);

      // randomized traffic with varying arrival rate
      do_reset();
      for (int i = 0; i < 900; i++) begin
         logic [NN*DW-1:0] rd;
         logic iv;
         for (int k = 0; k < NN; k++) rd[k*DW +: DW] = DW'($urandom);
         case ((i / 150) % 3)
            0:       iv = ($urandom_range(0, 5) == 0);
            1:       iv = ($urandom_range(0, 2) == 0);
            default: iv = ($urandom_range(0, 1) == 0);
         endcase
         step(iv, rd);
         if (i == 449) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
